// File: rtl/ex_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared encodings and helpers for the EX-stage multiply/divide unit.
//   md_op_e    : operation select presented on ex_muldiv.op
//   md_state_e : sequencer states of ex_muldiv
//   helpers    : operand classification and magnitude extraction
// ----------------------------------------------------------------------------
package ex_muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    // Magnitude of a 32-bit operand; unsigned operands pass through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [MD_WIDTH-1:0] md_mag(input logic [MD_WIDTH-1:0] v,
                                                   input logic               is_signed);
        return (is_signed && v[MD_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// Iterative radix-2 multiply/divide unit sitting beside the EX-stage ALU.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) over 32 CALC cycles,
// one FIX cycle for sign correction and a one-cycle DONE pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, overrides everything
//   start      in   request a new operation (honoured only in IDLE)
//   op         in   md_op_e encoding, sampled with start
//   src_a      in   multiplicand / dividend, sampled with start
//   src_b      in   multiplier / divisor, sampled with start
//   flush      in   synchronous abort, returns to IDLE without done
//   stall_req  out  combinational hold request for IF/ID/EX
//   busy       out  registered, high during CALC and FIX
//   done       out  registered one-cycle pulse, results valid
//   result_hi  out  product[63:32] / remainder
//   result_lo  out  product[31:0]  / quotient
// ----------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    md_state_e   state_q,   state_d;
    md_op_e      op_q,      op_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] a_q,       a_d;       // |multiplicand| or |dividend|
    logic [31:0] b_q,       b_d;       // |multiplier|  or |divisor|
    logic [31:0] a_raw_q,   a_raw_d;   // dividend as sampled, for divide by zero
    logic [63:0] acc_q,     acc_d;
    logic        neg_res_q, neg_res_d; // product / quotient must be negated
    logic        neg_rem_q, neg_rem_d; // remainder must be negated
    logic        dz_q,      dz_d;      // divide by zero
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic [31:0] res_hi_q,  res_hi_d;
    logic [31:0] res_lo_q,  res_lo_d;

    md_op_e      op_in;
    logic        in_signed;

    // Shift-add step: add the multiplicand into the top half when the
    // current multiplier bit (LSB first) is set, then shift right one place.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    // Restoring divide step: the remainder lives in acc[63:32], the quotient
    // shifts in from the right of acc[31:0]; dividend bits enter MSB first.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_borrow;
    logic [63:0] div_next;

    logic [63:0] prod_fixed;

    assign op_in     = md_op_e'(op);
    assign in_signed = md_is_signed(op_in);

    assign mul_sum  = {1'b0, acc_q[63:32]} + (b_q[cnt_q] ? {1'b0, a_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // ~cnt_q selects bit 31-cnt, i.e. the dividend MSB on the first step.
    assign div_shift  = {acc_q[63:32], a_q[~cnt_q]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, b_q};
    assign div_borrow = div_diff[33];
    assign div_next   = {(div_borrow ? div_shift[31:0] : div_diff[31:0]),
                         acc_q[30:0], ~div_borrow};

    assign prod_fixed = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    // NOTE: every signal driven here takes a default first so that no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        if (flush) begin
            // Abort: back to IDLE, results and done untouched.
            state_d = MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_d    = op_in;
                        a_d     = md_mag(src_a, in_signed);
                        b_d     = md_mag(src_b, in_signed);
                        a_raw_d = src_a;
                        dz_d    = md_is_div(op_in) && (src_b == 32'd0);
                        if (md_is_div(op_in)) begin
                            neg_res_d = in_signed && (src_a[31] ^ src_b[31]);
                            neg_rem_d = in_signed && src_a[31];
                        end else begin
                            neg_res_d = in_signed && (src_a[31] ^ src_b[31]);
                            neg_rem_d = 1'b0;
                        end
                        acc_d   = 64'd0;
                        cnt_d   = 5'd0;
                        state_d = MD_CALC;
                        busy_d  = 1'b1;
                    end
                end

                MD_CALC: begin
                    acc_d  = md_is_div(op_q) ? div_next : mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    busy_d = 1'b1;
                    if (cnt_q == 5'(MD_ITERS - 1)) begin
                        state_d = MD_FIX;
                    end
                end

                MD_FIX: begin
                    if (!md_is_div(op_q)) begin
                        res_hi_d = prod_fixed[63:32];
                        res_lo_d = prod_fixed[31:0];
                    end else if (dz_q) begin
                        res_hi_d = a_raw_q;
                        res_lo_d = 32'hFFFF_FFFF;
                    end else begin
                        res_hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                        res_lo_d = neg_res_q ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
                    end
                    state_d = MD_DONE;
                    done_d  = 1'b1;
                end

                MD_DONE: begin
                    state_d = MD_IDLE;
                end

                default: begin
                    state_d = MD_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MULT;
            cnt_q     <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            a_raw_q   <= 32'd0;
            acc_q     <= 64'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_hi_q  <= 32'd0;
            res_lo_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
        end
    end

    // Low in DONE so EX/MEM captures the result on the DONE edge.
    assign stall_req = ((state_q == MD_IDLE) && start && !flush)
                     || (state_q == MD_CALC)
                     || (state_q == MD_FIX);

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
// Directed bench for ex_muldiv: hand-computed multiply/divide vectors,
// latency and stall window, divide-by-zero, overflow divide, flush and reset.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current (IDLE) cycle, which is cycle 0.
    // Checks stall window, 34-cycle latency, results and return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        bit window_ok;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        check({tag, "_stall_c0"}, 64'(stall_req), 64'd1);
        cyc       = 0;
        window_ok = 1'b1;
        do begin
            tick();
            start = 1'b0;
            cyc++;
            if (done !== 1'b1 && (stall_req !== 1'b1 || busy !== 1'b1)) window_ok = 1'b0;
        end while (done !== 1'b1 && cyc < 40);
        check({tag, "_latency"},   64'(cyc),       64'd34);
        check({tag, "_stall_win"}, 64'(window_ok), 64'd1);
        check({tag, "_stall_done"},64'(stall_req), 64'd0);
        check({tag, "_busy_done"}, 64'(busy),      64'd0);
        check({tag, "_hi"},        64'(result_hi), 64'(exp_hi));
        check({tag, "_lo"},        64'(result_lo), 64'(exp_lo));
        tick();
        check({tag, "_done_drop"}, 64'(done),      64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        src_a = 32'd0;
        src_b = 32'd0;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_hi",    64'(result_hi), 64'd0);
        check("rst_lo",    64'(result_lo), 64'd0);

        tick();
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_zero", OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

        // DIVU 50/5 aborted by flush at cycle 10
        op    = OP_DIVU;
        src_a = 32'd50;
        src_b = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_busy",  64'(busy),      64'd0);
        check("flush_done",  64'(done),      64'd0);
        check("flush_stall", 64'(stall_req), 64'd0);
        check("flush_hi",    64'(result_hi), 64'd2);
        check("flush_lo",    64'(result_lo), 64'd14);
        tick();
        check("flush_hold_done", 64'(done), 64'd0);

        run_op("divu_50_5", OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10);

        // flush together with start: start ignored
        op    = OP_MULTU;
        src_a = 32'd3;
        src_b = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_start_stall", 64'(stall_req), 64'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_start_busy",  64'(busy),      64'd0);
        check("flush_start_hi",    64'(result_hi), 64'd0);
        check("flush_start_lo",    64'(result_lo), 64'd10);

        // rst at cycle 20 of a MULT
        op    = OP_MULT;
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        #1;
        check("mrst_busy",  64'(busy),      64'd0);
        check("mrst_done",  64'(done),      64'd0);
        check("mrst_stall", 64'(stall_req), 64'd0);
        check("mrst_hi",    64'(result_hi), 64'd0);
        check("mrst_lo",    64'(result_lo), 64'd0);
        rst = 1'b0;
        tick();

        run_op("mult_after_rst", OP_MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
